ap_mult_arb_4r: RTL and testbench

AP_MULT_ARB_4R -- requirements
Module: ap_mult_arb_4r

---
 rtl/ap_mult_arb_4r.sv | 203 ++++++++++++++++++++
 tb/tb_ap_mult_arb_4r.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_mult_arb_4r.sv
// Round-robin arbiter sharing one signed multiplier among NREQ requesters.
// Two-stage pipeline: S1 holds the granted operands, S2 holds the registered product.

module ap_si_wall_12b_r11 #(
  parameter int unsigned DW = 12
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [2*DW-1:0] o_p
);

  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned NROWS = DW + 1;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_pp  [NROWS];
  logic [PW-1:0] w_red [NROWS];
  logic [PW-1:0] w_sum;
  logic [PW-1:0] r_p;

  // The sign row is subtracted as ~row + 1; the +1 travels as its own row.
  always_comb begin
    w_a_ext = {{DW{i_a[DW-1]}}, i_a};
    for (int i = 0; i < NROWS; i++) begin
      w_pp[i] = '0;
    end
    for (int i = 0; i < DW - 1; i++) begin
      w_pp[i] = i_b[i] ? (w_a_ext << i) : '0;
    end
    w_pp[DW-1] = ~(i_b[DW-1] ? (w_a_ext << (DW - 1)) : '0);
    w_pp[DW]   = PW'(1);
  end

  // Wallace reduction: each level compresses groups of three rows into two.
  always_comb begin
    logic [PW-1:0] row [NROWS];
    logic [PW-1:0] nxt [NROWS];
    logic [PW-1:0] x, y, z;
    int n, m;
    for (int j = 0; j < NROWS; j++) begin
      row[j] = w_pp[j];
      nxt[j] = '0;
    end
    x = '0;
    y = '0;
    z = '0;
    n = NROWS;
    m = 0;
    for (int lvl = 0; lvl < NROWS; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int j = 0; j < NROWS; j++) begin
          nxt[j] = '0;
        end
        for (int g = 0; g < NROWS / 3; g++) begin
          if (3 * g + 2 < n) begin
            x        = row[3*g];
            y        = row[3*g+1];
            z        = row[3*g+2];
            nxt[m]   = x ^ y ^ z;
            nxt[m+1] = ((x & y) | (x & z) | (y & z)) << 1;
            m        = m + 2;
          end
        end
        for (int j = 0; j < NROWS; j++) begin
          if (j >= 3 * (n / 3) && j < n) begin
            nxt[m] = row[j];
            m      = m + 1;
          end
        end
        for (int j = 0; j < NROWS; j++) begin
          row[j] = nxt[j];
        end
        n = m;
      end
    end
    for (int j = 0; j < NROWS; j++) begin
      w_red[j] = row[j];
    end
  end

  assign w_sum = w_red[0] + w_red[1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p <= w_sum;
    end
  end

  assign o_p = r_p;

endmodule

module ap_mult_arb_4r #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 12,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_muld,
  input  logic [NREQ*DW-1:0]   req_mulr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*DW-1:0]      res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  logic            r_v1;
  logic            r_v2;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id1;
  logic [IDW-1:0]  r_id2;
  logic [DW-1:0]   r_muld;
  logic [DW-1:0]   r_mulr;

  logic            w_s2_adv;
  logic            w_s1_acc;
  logic            w_found;
  logic            w_accept;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_rr_nxt;

  assign w_s2_adv = !r_v2 || res_ready;
  assign w_s1_acc = !r_v1 || w_s2_adv;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= int'(NREQ)) begin
        idx = idx - int'(NREQ);
      end
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_rr_nxt = '0;
    if (int'(w_gnt) != int'(NREQ) - 1) begin
      w_rr_nxt = w_gnt + IDW'(1);
    end
  end

  // Reset gating keeps req_ready low while rst_n is asserted.
  assign req_ready = (rst_n && w_found && w_s1_acc) ? (NREQ'(1) << w_gnt) : '0;
  assign w_accept  = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_rr_ptr <= '0;
      r_id1    <= '0;
      r_id2    <= '0;
    end else begin
      if (w_s2_adv) begin
        r_v2  <= r_v1;
        r_id2 <= r_id1;
      end
      if (w_s1_acc) begin
        r_v1 <= w_accept;
      end
      if (w_accept) begin
        r_id1    <= w_gnt;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_muld <= req_muld[w_gnt*DW +: DW];
      r_mulr <= req_mulr[w_gnt*DW +: DW];
    end
  end

  ap_si_wall_12b_r11 #(
    .DW (DW)
  ) u_mult (
    .clk  (clk),
    .i_en (w_s2_adv),
    .i_a  (r_muld),
    .i_b  (r_mulr),
    .o_p  (res_data)
  );

  assign res_valid = r_v2;
  assign res_id    = r_id2;
  assign busy      = r_v1 | r_v2;

endmodule

// File: tb/tb_ap_mult_arb_4r.sv
// Directed and randomized checks of the round-robin shared multiplier.

module tb_ap_mult_arb_4r;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_muld;
  logic [NREQ*DW-1:0]   req_mulr;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*DW-1:0]      res_data;
  logic [IDW-1:0]       res_id;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;

  // Lane i: muld = i+1, mulr = -(i+2); products -2, -6, -12, -20.
  logic [2*DW-1:0] fexp [NREQ] = '{24'hFFFFFE, 24'hFFFFFA, 24'hFFFFF4, 24'hFFFFEC};

  ap_mult_arb_4r #(
    .NREQ (NREQ),
    .DW   (DW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_muld  (req_muld),
    .req_mulr  (req_mulr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_fixed_lanes();
    req_muld = {12'd4, 12'd3, 12'd2, 12'd1};
    req_mulr = {12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    load_fixed_lanes();
    #3;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    step();
    req_valid = '0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_muld  = '0;
    req_mulr  = '0;
    req_muld[2*DW +: DW] = 12'd3;
    req_mulr[2*DW +: DW] = 12'hFFB;
    req_valid = 4'b0100;
    res_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_cycle1: got valid=%b busy=%b want valid=0 busy=1", res_valid, busy); end
    step();
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd2) begin n_err++; $display("FAIL single_result: got valid=%b id=%0d want valid=1 id=2", res_valid, res_id); end
    n_vec++; if (res_data !== 24'hFFFFF1) begin n_err++; $display("FAIL single_data: got %h want fffff1", res_data); end
    step();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_drain: got valid=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_fairness();
    apply_reset();
    load_fixed_lanes();
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        n_vec++;
        if (req_ready !== (4'b0001 << (c % 4))) begin
          n_err++; $display("FAIL fair_grant c%0d: got %b want %b", c, req_ready, 4'b0001 << (c % 4));
        end
      end
      if (c >= 2) begin
        n_vec++;
        if (res_valid !== 1'b1 || res_id !== IDW'((c - 2) % 4) || res_data !== fexp[(c-2)%4]) begin
          n_err++; $display("FAIL fair_result c%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                            c, res_valid, res_id, res_data, (c - 2) % 4, fexp[(c-2)%4]);
        end
      end
      step();
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int accepts;
    apply_reset();
    load_fixed_lanes();
    accepts   = 0;
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (req_ready != 0) accepts++;
      if (c >= 2) begin
        n_vec++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== fexp[0]) begin
          n_err++; $display("FAIL bp_hold c%0d: got v=%b id=%0d d=%h want v=1 id=0 d=%h",
                            c, res_valid, res_id, res_data, fexp[0]);
        end
      end
      if (c == 4) begin
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready: got %b want 0000", req_ready); end
      end
      step();
    end
    n_vec++; if (accepts != 2) begin n_err++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin n_err++; $display("FAIL bp_rel0: got v=%b id=%0d want v=1 id=0", res_valid, res_id); end
    step();
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== fexp[1]) begin n_err++; $display("FAIL bp_rel1: got v=%b id=%0d d=%h want v=1 id=1 d=%h", res_valid, res_id, res_data, fexp[1]); end
    step();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drain: got v=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    load_fixed_lanes();
    res_ready = 1'b0;
    req_valid = 4'b0011;
    step();
    step();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sim_accept: got %b want 0001", req_ready); end
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin n_err++; $display("FAIL sim_output: got v=%b id=%0d want v=1 id=0", res_valid, res_id); end
    step();
    req_valid = '0;
    #1;
    n_vec++; if (busy !== 1'b1 || res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== fexp[1]) begin
      n_err++; $display("FAIL sim_next: got busy=%b v=%b id=%0d d=%h want 1 1 1 %h", busy, res_valid, res_id, res_data, fexp[1]);
    end
    step();
    n_vec++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== fexp[0]) begin
      n_err++; $display("FAIL sim_reissue: got v=%b id=%0d d=%h want 1 0 %h", res_valid, res_id, res_data, fexp[0]);
    end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sim_drain: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_fixed_lanes();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    step();
    step();
    n_vec++; if (busy !== 1'b1 || res_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got busy=%b v=%b want 1 1", busy, res_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL rmid_reset: got v=%b busy=%b rdy=%b want 0 0 0000", res_valid, busy, req_ready);
    end
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    res_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_first: got %b want 0001", req_ready); end
    step();
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmid_second: got %b want 1000", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_soak();
    logic [IDW+2*DW-1:0] sb [$];
    logic [IDW+2*DW-1:0] exp_e;
    logic [2*DW-1:0]     prod;
    logic [DW-1:0]       a, b;
    logic [NREQ-1:0]     acc_mask;
    int                  wait_cnt [NREQ];
    logic                prev_stall;
    logic [IDW-1:0]      prev_id;
    logic [2*DW-1:0]     prev_data;
    apply_reset();
    req_muld   = '0;
    req_mulr   = '0;
    prev_stall = 1'b0;
    prev_id    = '0;
    prev_data  = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (prev_stall) begin
        n_vec++;
        if (res_valid !== 1'b1 || res_id !== prev_id || res_data !== prev_data) begin
          n_err++; $display("FAIL soak_stable cyc%0d: got v=%b id=%0d d=%h want 1 %0d %h",
                            cyc, res_valid, res_id, res_data, prev_id, prev_data);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_muld[i*DW +: DW] = DW'($urandom);
          req_mulr[i*DW +: DW] = DW'($urandom);
        end
      end
      #1;
      n_vec++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 0) begin
        n_err++; $display("FAIL soak_onehot cyc%0d: got rdy=%b valid=%b", cyc, req_ready, req_valid);
      end
      acc_mask = req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          a    = req_muld[i*DW +: DW];
          b    = req_mulr[i*DW +: DW];
          prod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
          sb.push_back({IDW'(i), prod});
          wait_cnt[i] = 0;
        end else if (req_valid[i] && acc_mask != 0) begin
          wait_cnt[i]++;
          n_vec++;
          if (wait_cnt[i] > NREQ - 1) begin
            n_err++; $display("FAIL soak_starve cyc%0d lane%0d: got %0d waits want <= %0d", cyc, i, wait_cnt[i], NREQ - 1);
          end
        end
      end
      if (res_valid && res_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL soak_extra cyc%0d: got id=%0d d=%h want no result", cyc, res_id, res_data);
        end else begin
          exp_e = sb.pop_front();
          if ({res_id, res_data} !== exp_e) begin
            n_err++; $display("FAIL soak_result cyc%0d: got id=%0d d=%h want id=%0d d=%h",
                              cyc, res_id, res_data, exp_e[IDW+2*DW-1 -: IDW], exp_e[2*DW-1:0]);
          end
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_id    = res_id;
      prev_data  = res_data;
      step();
      req_valid = req_valid & ~acc_mask;
    end
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (res_valid) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL drain_extra: got id=%0d want no result", res_id);
        end else begin
          exp_e = sb.pop_front();
          if ({res_id, res_data} !== exp_e) begin
            n_err++; $display("FAIL drain_result: got id=%0d d=%h want id=%0d d=%h",
                              res_id, res_data, exp_e[IDW+2*DW-1 -: IDW], exp_e[2*DW-1:0]);
          end
        end
      end
      step();
    end
    n_vec++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL soak_lost: got %0d pending busy=%b want 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_muld  = '0;
    req_mulr  = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
